pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 105 ++++++++++
 tb/tb_pc_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter unit: BOOT/RUN/HALT sequencing with prioritised redirects,
// traps on external request or misaligned targets, and a fetch handshake.
module pc_unit #(
   parameter int            N            = 32,
   parameter logic [N-1:0]  RESET_VECTOR = N'(32'h00400000),
   parameter logic [N-1:0]  TRAP_VECTOR  = N'(32'h00400180),
   parameter int            INC          = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         branch_en,
   input  logic [N-1:0] branch_target,
   input  logic         jump_en,
   input  logic [N-1:0] jump_target,
   input  logic         trap_req,
   input  logic         xret,
   input  logic         halt_req,
   input  logic         resume,
   input  logic         pc_ready,
   output logic [N-1:0] pc_value,
   output logic         pc_valid,
   output logic [N-1:0] epc,
   output logic [1:0]   cause,
   output logic         halted
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam logic [1:0] CAUSE_NONE      = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN  = 2'd1;
   localparam logic [1:0] CAUSE_EXTERNAL  = 2'd2;

   state_t       state;
   logic         jb_taken;
   logic [N-1:0] jb_target;
   logic         jb_misaligned;

   // Jump outranks branch when both are requested in the same cycle.
   always_comb begin
      jb_taken      = jump_en | branch_en;
      jb_target     = jump_en ? jump_target : branch_target;
      jb_misaligned = |jb_target[1:0];
   end

   // Registered outputs track the state; pc_valid only in RUN, halted only in HALT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= BOOT;
         pc_value <= RESET_VECTOR;
         pc_valid <= 1'b0;
         epc      <= '0;
         cause    <= CAUSE_NONE;
         halted   <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state    <= RUN;
               pc_valid <= 1'b1;
            end
            RUN: begin
               if (trap_req) begin
                  pc_value <= TRAP_VECTOR;
                  epc      <= pc_value;
                  cause    <= CAUSE_EXTERNAL;
               end else if (xret) begin
                  pc_value <= epc;
                  cause    <= CAUSE_NONE;
               end else if (jb_taken) begin
                  if (jb_misaligned) begin
                     pc_value <= TRAP_VECTOR;
                     epc      <= pc_value;
                     cause    <= CAUSE_MISALIGN;
                  end else begin
                     pc_value <= jb_target;
                  end
               end else if (halt_req) begin
                  state    <= HALT;
                  pc_valid <= 1'b0;
                  halted   <= 1'b1;
               end else if (pc_ready) begin
                  pc_value <= pc_value + N'(INC);
               end
            end
            HALT: begin
               if (trap_req) begin
                  pc_value <= TRAP_VECTOR;
                  epc      <= pc_value;
                  cause    <= CAUSE_EXTERNAL;
               end
               if (trap_req || resume) begin
                  state    <= RUN;
                  pc_valid <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            default: begin
               state    <= BOOT;
               pc_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset, branch_en, jump_en, trap_req, xret, halt_req, resume, pc_ready;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_value, epc;
   logic        pc_valid, halted;
   logic [1:0]  cause;

   logic        reset8, ready8;
   logic        zero1 = 1'b0;
   logic [7:0]  zero8 = 8'h00;
   logic [7:0]  pc8, epc8;
   logic        valid8, halted8;
   logic [1:0]  cause8;

   int passCount  = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .reset(reset),
      .branch_en(branch_en), .branch_target(branch_target),
      .jump_en(jump_en), .jump_target(jump_target),
      .trap_req(trap_req), .xret(xret), .halt_req(halt_req), .resume(resume),
      .pc_ready(pc_ready), .pc_value(pc_value), .pc_valid(pc_valid),
      .epc(epc), .cause(cause), .halted(halted)
   );

   pc_unit #(.N(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .INC(4)) dut8 (
      .clk(clk), .reset(reset8),
      .branch_en(zero1), .branch_target(zero8),
      .jump_en(zero1), .jump_target(zero8),
      .trap_req(zero1), .xret(zero1), .halt_req(zero1), .resume(zero1),
      .pc_ready(ready8), .pc_value(pc8), .pc_valid(valid8),
      .epc(epc8), .cause(cause8), .halted(halted8)
   );

   // Architectural view of the unit: mode 0 = boot, 1 = run, 2 = halt.
   typedef struct {
      bit          known;
      int          mode;
      logic [31:0] pc;
      logic [31:0] epc;
      logic [1:0]  cause;
   } model_t;

   model_t m = '{known: 1'b0, mode: 0, pc: 32'h0, epc: 32'h0, cause: 2'd0};

   function automatic model_t modelStep(input model_t s);
      model_t n = s;
      logic [31:0] tgt;
      if (reset) begin
         n = '{known: 1'b1, mode: 0, pc: 32'h00400000, epc: 32'h0, cause: 2'd0};
      end else if (!s.known) begin
         n = s;
      end else if (s.mode == 0) begin
         n.mode = 1;
      end else if (s.mode == 2) begin
         if (trap_req) begin
            n.epc = s.pc; n.pc = 32'h00400180; n.cause = 2; n.mode = 1;
         end else if (resume) begin
            n.mode = 1;
         end
      end else begin
         tgt = jump_en ? jump_target : branch_target;
         if (trap_req) begin
            n.epc = s.pc; n.pc = 32'h00400180; n.cause = 2;
         end else if (xret) begin
            n.pc = s.epc; n.cause = 0;
         end else if (jump_en || branch_en) begin
            if (tgt % 4 != 0) begin
               n.epc = s.pc; n.pc = 32'h00400180; n.cause = 1;
            end else begin
               n.pc = tgt;
            end
         end else if (halt_req) begin
            n.mode = 2;
         end else if (pc_ready) begin
            n.pc = s.pc + 32'd4;
         end
      end
      return n;
   endfunction

   always @(posedge clk) m <= modelStep(m);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Model comparison one time unit after every edge, once the model has seen a reset.
   always @(posedge clk) begin
      #1;
      if (m.known) begin
         checkOutput("model pc_value", pc_value, m.pc);
         checkOutput("model pc_valid", {31'b0, pc_valid}, {31'b0, m.mode == 1});
         checkOutput("model halted", {31'b0, halted}, {31'b0, m.mode == 2});
         checkOutput("model epc", epc, m.epc);
         checkOutput("model cause", {30'b0, cause}, {30'b0, m.cause});
      end
   end

   // Drive one cycle of inputs, then return just after the edge that consumes them.
   task automatic applyStimulus(input bit rst, br, jmp, trp, xr, hlt, res, rdy,
                                input logic [31:0] bt, jt);
      reset = rst; branch_en = br; jump_en = jmp; trap_req = trp;
      xret = xr; halt_req = hlt; resume = res; pc_ready = rdy;
      branch_target = bt; jump_target = jt;
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1; branch_en = 0; jump_en = 0; trap_req = 0; xret = 0;
      halt_req = 0; resume = 0; pc_ready = 0; branch_target = 0; jump_target = 0;
      reset8 = 1'b1; ready8 = 1'b0;

      // reset, boot, sequential fetch
      applyStimulus(1,0,0,0,0,0,0,1, 0, 0);
      checkOutput("reset pc_valid", {31'b0, pc_valid}, 32'd0);
      checkOutput("reset pc_value", pc_value, 32'h00400000);
      checkOutput("reset cause", {30'b0, cause}, 32'd0);
      applyStimulus(0,0,0,0,0,0,0,1, 0, 0);
      checkOutput("boot exit valid", {31'b0, pc_valid}, 32'd1);
      checkOutput("first pc", pc_value, 32'h00400000);
      applyStimulus(0,0,0,0,0,0,0,1, 0, 0);
      checkOutput("second pc", pc_value, 32'h00400004);
      applyStimulus(0,0,0,0,0,0,0,1, 0, 0);
      checkOutput("third pc", pc_value, 32'h00400008);

      // stall, then branch during stall
      repeat (3) applyStimulus(0,0,0,0,0,0,0,0, 0, 0);
      checkOutput("stall pc", pc_value, 32'h00400008);
      checkOutput("stall valid", {31'b0, pc_valid}, 32'd1);
      applyStimulus(0,1,0,0,0,0,0,0, 32'h00400100, 0);
      checkOutput("branch in stall", pc_value, 32'h00400100);

      // jump beats branch; misaligned branch traps
      applyStimulus(0,1,1,0,0,0,0,1, 32'h00400300, 32'h00400200);
      checkOutput("jump priority", pc_value, 32'h00400200);
      applyStimulus(0,1,0,0,0,0,0,1, 32'h00400302, 0);
      checkOutput("misalign pc", pc_value, 32'h00400180);
      checkOutput("misalign cause", {30'b0, cause}, 32'd1);
      checkOutput("misalign epc", epc, 32'h00400200);

      // external trap and return
      applyStimulus(0,0,1,0,0,0,0,1, 0, 32'h00400010);
      applyStimulus(0,0,0,1,0,0,0,1, 0, 0);
      checkOutput("trap pc", pc_value, 32'h00400180);
      checkOutput("trap epc", epc, 32'h00400010);
      checkOutput("trap cause", {30'b0, cause}, 32'd2);
      applyStimulus(0,0,0,0,0,0,0,1, 0, 0);
      checkOutput("trap handler step", pc_value, 32'h00400184);
      applyStimulus(0,0,0,0,1,0,0,1, 0, 0);
      checkOutput("xret pc", pc_value, 32'h00400010);
      checkOutput("xret cause", {30'b0, cause}, 32'd0);

      // halt, ignored branch, resume, reset from halt
      applyStimulus(0,0,0,0,0,1,0,1, 0, 0);
      checkOutput("halt halted", {31'b0, halted}, 32'd1);
      checkOutput("halt valid", {31'b0, pc_valid}, 32'd0);
      applyStimulus(0,1,0,0,0,0,0,1, 32'h00400100, 0);
      checkOutput("halt ignores branch", pc_value, 32'h00400010);
      applyStimulus(0,0,0,0,0,0,1,1, 0, 0);
      checkOutput("resume valid", {31'b0, pc_valid}, 32'd1);
      checkOutput("resume pc", pc_value, 32'h00400010);
      applyStimulus(0,0,0,0,0,1,0,1, 0, 0);
      applyStimulus(1,0,0,0,0,0,0,1, 0, 0);
      checkOutput("reset in halt pc", pc_value, 32'h00400000);
      checkOutput("reset in halt halted", {31'b0, halted}, 32'd0);

      // randomized traffic, checked by the model process
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] bt, jt;
         bt = {$urandom} & 32'hFFFF_FFFC;
         jt = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) jt[1:0] = 2'($urandom_range(1, 3));
         applyStimulus($urandom_range(0, 99) < 2,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 9) < 7, bt, jt);
      end

      // narrow instance wraps modulo 2^8
      ready8 = 1'b1;
      @(posedge clk); #2;
      reset8 = 1'b0;
      @(posedge clk); #2;
      checkOutput("n8 first", {24'b0, pc8}, 32'hF8);
      @(posedge clk); #2;
      checkOutput("n8 second", {24'b0, pc8}, 32'hFC);
      @(posedge clk); #2;
      checkOutput("n8 wrap", {24'b0, pc8}, 32'h00);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
